// File: rtl/fpir_denormalizer.sv
// fpir_denormalizer: iterative right-shift aligner that raises an FPIR operand's exponent to a target, folding lost bits into sticky
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`define FPIR_TYPE_NORMAL 3'd0
`define FPIR_TYPE_PZERO 3'd1
`define FPIR_TYPE_MZERO 3'd2
`define FPIR_TYPE_PINF 3'd3
`define FPIR_TYPE_MINF 3'd4
`define FPIR_TYPE_NAN 3'd5
`endif
module fpir_denormalizer #(
  parameter int BW_EXPONENT = 8,
  parameter int BW_SIGNIFICAND = 24,
  parameter int BW_GUARD = 3,
  parameter int BW_OVERFLOW = 2,
  parameter int SHIFT_PER_CYCLE = 4,
  localparam int BW_FPIR_VALUE = `BW_FPIR_TYPE + 1 + BW_EXPONENT + BW_SIGNIFICAND + BW_GUARD + BW_OVERFLOW
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  input  logic s_valid,
  output logic s_ready,
  input  logic [BW_FPIR_VALUE-1:0] s_value,
  input  logic [BW_OVERFLOW+BW_EXPONENT-1:0] s_target_exponent,
  output logic m_valid,
  input  logic m_ready,
  output logic [BW_FPIR_VALUE-1:0] m_value,
  output logic m_underflow_shift,
  output logic m_target_below
);
  localparam int TW = `BW_FPIR_TYPE;
  localparam int W = BW_SIGNIFICAND + BW_GUARD;
  localparam int EW = BW_OVERFLOW + BW_EXPONENT;
  localparam int CW = $clog2(W + 2);
  localparam logic signed [EW:0] LIM = (EW+1)'(W + 1);
  localparam logic [CW-1:0] SPC = CW'(SHIFT_PER_CYCLE);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] type_q, s_type;
  logic sign_q, below_q, under_q, s_norm, lost;
  logic [EW-1:0] exp_q, tgt_q, s_exp;
  logic [W-1:0] ext_q, ext_d, s_ext, sh;
  logic [CW-1:0] rem_q, step, rem_init;
  logic signed [EW:0] diff;
  assign s_type = s_value[BW_FPIR_VALUE-1 -: TW];
  assign s_exp = {s_value[BW_OVERFLOW-1:0], s_value[BW_FPIR_VALUE-TW-2 -: BW_EXPONENT]};
  assign s_ext = s_value[BW_OVERFLOW +: W];
  assign s_norm = s_type == `FPIR_TYPE_NORMAL;
  assign diff = $signed({s_target_exponent[EW-1], s_target_exponent}) - $signed({s_exp[EW-1], s_exp});
  // clamp before loading so large distances never wrap the counter
  assign rem_init = diff >= LIM ? CW'(W + 1) : diff[CW-1:0];
  assign step = rem_q < SPC ? rem_q : SPC;
  assign sh = ext_q >> step;
  assign lost = |(ext_q & ~({W{1'b1}} << step));
  assign ext_d = {sh[W-1:1], sh[0] | lost};
  assign s_ready = state_q == IDLE;
  assign m_valid = state_q == DONE;
  assign m_value = {type_q, sign_q, exp_q[BW_EXPONENT-1:0], ext_q, exp_q[EW-1 -: BW_OVERFLOW]};
  assign m_underflow_shift = under_q;
  assign m_target_below = below_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (s_valid) state_d = (s_norm && diff > 0) ? SHIFT : DONE;
      SHIFT: if (rem_q == step) state_d = DONE;
      DONE: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn || clear) begin
      type_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      tgt_q <= '0;
      ext_q <= '0;
      rem_q <= '0;
      below_q <= 1'b0;
      under_q <= 1'b0;
    end else if (state_q == IDLE && s_valid) begin
      type_q <= s_type;
      sign_q <= s_value[BW_FPIR_VALUE-TW-1];
      exp_q <= s_exp;
      tgt_q <= s_target_exponent;
      ext_q <= s_ext;
      rem_q <= rem_init;
      below_q <= s_norm && diff < 0;
      under_q <= s_norm && diff >= LIM;
    end else if (state_q == SHIFT) begin
      ext_q <= ext_d;
      rem_q <= rem_q - step;
      if (rem_q == step) begin
        exp_q <= tgt_q;
        if (ext_d == '0) type_q <= sign_q ? `FPIR_TYPE_MZERO : `FPIR_TYPE_PZERO;
      end
    end else if (state_q == DONE && m_ready) begin
      below_q <= 1'b0;
      under_q <= 1'b0;
    end
endmodule

// File: tb/tb_fpir_denormalizer.sv
// tb_fpir_denormalizer: directed vectors for the FPIR right-shift aligner
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`define FPIR_TYPE_NORMAL 3'd0
`define FPIR_TYPE_PZERO 3'd1
`define FPIR_TYPE_MZERO 3'd2
`define FPIR_TYPE_PINF 3'd3
`define FPIR_TYPE_MINF 3'd4
`define FPIR_TYPE_NAN 3'd5
`endif
module tb_fpir_denormalizer;
  localparam int VW = 41;
  logic clk = 1'b0, rstnn = 1'b0, clear = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic s_ready, m_valid, m_underflow_shift, m_target_below;
  logic [VW-1:0] s_value = '0, m_value, held;
  logic [9:0] s_target_exponent = '0;
  int checks = 0, errors = 0, lat;
  fpir_denormalizer dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_value(s_value), .s_target_exponent(s_target_exponent), .m_valid(m_valid),
    .m_ready(m_ready), .m_value(m_value), .m_underflow_shift(m_underflow_shift),
    .m_target_below(m_target_below)
  );
  always #5 clk = ~clk;
  function automatic logic [VW-1:0] mk(input logic [2:0] t, input logic s, input logic [9:0] e, input logic [26:0] x);
    return {t, s, e[7:0], x, e[9:8]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [VW-1:0] v, input logic [9:0] t);
    @(negedge clk);
    s_valid = 1'b1;
    s_value = v;
    s_target_exponent = t;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask
  task automatic wait_valid(output int l);
    l = 1;
    while (!m_valid && l < 100) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic ack();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    chk("ack_s_ready", s_ready, 1);
    chk("ack_m_valid", m_valid, 0);
  endtask
  task automatic run(input string tag, input logic [VW-1:0] v, input logic [9:0] t,
                     input logic [VW-1:0] ev, input logic eu, input logic eb, input int el);
    start(v, t);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_val"}, m_value, ev);
    chk({tag, "_under"}, m_underflow_shift, eu);
    chk({tag, "_below"}, m_target_below, eb);
    ack();
  endtask
  initial begin
    #12;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_value", m_value, 0);
    chk("rst_flags", {m_underflow_shift, m_target_below}, 0);
    @(negedge clk) rstnn = 1'b1;
    start(mk(`FPIR_TYPE_NORMAL, 0, 10'd100, 27'h4000001), 10'd103);
    wait_valid(lat);
    chk("basic_lat", lat, 2);
    chk("basic_val", m_value, mk(`FPIR_TYPE_NORMAL, 0, 10'd103, 27'h0800001));
    chk("basic_flags", {m_underflow_shift, m_target_below}, 0);
    held = m_value;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_val", m_value, held);
      chk("hold_s_ready", s_ready, 0);
      chk("hold_m_valid", m_valid, 1);
    end
    ack();
    run("under", mk(`FPIR_TYPE_NORMAL, 0, 10'd10, 27'h4000000), 10'd50,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd50, 27'h0000001), 1, 0, 8);
    run("mzero", mk(`FPIR_TYPE_NORMAL, 1, 10'd20, 27'h0), 10'd25,
        mk(`FPIR_TYPE_MZERO, 1, 10'd25, 27'h0), 0, 0, 3);
    run("pinf", mk(`FPIR_TYPE_PINF, 0, 10'd100, 27'h4000000), 10'd120,
        mk(`FPIR_TYPE_PINF, 0, 10'd100, 27'h4000000), 0, 0, 1);
    run("below", mk(`FPIR_TYPE_NORMAL, 0, 10'd100, 27'h4123456), 10'd90,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd100, 27'h4123456), 0, 1, 1);
    run("equal", mk(`FPIR_TYPE_NORMAL, 1, 10'd77, 27'h5555555), 10'd77,
        mk(`FPIR_TYPE_NORMAL, 1, 10'd77, 27'h5555555), 0, 0, 1);
    run("negexp", mk(`FPIR_TYPE_NORMAL, 0, 10'h3FB, 27'h000001F), 10'd0,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd0, 27'h0000001), 0, 0, 3);
    run("exact28", mk(`FPIR_TYPE_NORMAL, 0, 10'd0, 27'h4000000), 10'd28,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd28, 27'h0000001), 1, 0, 8);
    run("exact27", mk(`FPIR_TYPE_NORMAL, 0, 10'd0, 27'h4000000), 10'd27,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd27, 27'h0000001), 0, 0, 8);
    start(mk(`FPIR_TYPE_NORMAL, 0, 10'd10, 27'h4000000), 10'd50);
    repeat (2) @(posedge clk);
    #2 rstnn = 1'b0;
    #1;
    chk("arst_s_ready", s_ready, 1);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_value", m_value, 0);
    @(negedge clk) rstnn = 1'b1;
    run("post_rst", mk(`FPIR_TYPE_NORMAL, 0, 10'd100, 27'h4000001), 10'd103,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd103, 27'h0800001), 0, 0, 2);
    start(mk(`FPIR_TYPE_NORMAL, 0, 10'd10, 27'h4000000), 10'd50);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr_s_ready", s_ready, 1);
    chk("clr_m_valid", m_valid, 0);
    chk("clr_flags", {m_underflow_shift, m_target_below}, 0);
    repeat (10) @(posedge clk);
    #1 chk("clr_idle", {s_ready, m_valid}, 2'b10);
    @(negedge clk);
    clear = 1'b1;
    s_valid = 1'b1;
    s_value = mk(`FPIR_TYPE_PINF, 0, 10'd1, 27'h1);
    @(posedge clk);
    #1 clear = 1'b0;
    s_valid = 1'b0;
    chk("clr_sv_ready", s_ready, 1);
    @(posedge clk);
    #1 chk("clr_sv_valid", m_valid, 0);
    run("post_clr", mk(`FPIR_TYPE_NORMAL, 0, 10'd10, 27'h4000000), 10'd50,
        mk(`FPIR_TYPE_NORMAL, 0, 10'd50, 27'h0000001), 1, 0, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpir_denormalizer.md
Name: fpir_denormalizer

Overview:
- Iterative right-shift aligner for FPIR values; the inverse of the FPIR normalizer.
- Raises an FPIR operand's exponent to a caller-supplied target exponent and shifts the extended significand (significand+guard) right by the difference.
- All shifted-out bits are folded into a sticky LSB.
- Sits ahead of FPIR adders (operand alignment) and FPIR-to-IEEE packers (subnormal generation). Uses a valid/ready handshake on both sides.

Parameters:
- BW_EXPONENT, 8, FPIR exponent field width.
- BW_SIGNIFICAND, 24, FPIR significand field width (hidden bit included).
- BW_GUARD, 3, FPIR guard field width; its LSB acts as sticky.
- BW_OVERFLOW, 2, FPIR exponent overflow/sign-extension field width.
- SHIFT_PER_CYCLE, 4, maximum right-shift distance per SHIFT cycle (1..W, where W = BW_SIGNIFICAND+BW_GUARD).

Ports:
- clk  input  1  clock.
- rstnn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: return to IDLE and drop any held result.
- s_valid  input  1  input operand valid.
- s_ready  output  1  block can accept an operand.
- s_value  input  BW_FPIR_VALUE  FPIR operand {type, sign, exponent, significand, guard, overflow}; type width is `BW_FPIR_TYPE.
- s_target_exponent  input  BW_OVERFLOW+BW_EXPONENT  signed extended target exponent {overflow, exponent}.
- m_valid  output  1  result valid.
- m_ready  input  1  consumer accepts the result.
- m_value  output  BW_FPIR_VALUE  aligned FPIR result, same field layout.
- m_underflow_shift  output  1  the requested shift was at least W+1, so all significand bits went to sticky.
- m_target_below  output  1  the target was below the operand exponent; the operand is passed through unchanged.

Behaviour:
- Reset (async, rstnn=0):
  - State goes to IDLE.
  - s_ready=1, m_valid=0, m_value=0, both flags 0.
  - An in-flight operation is discarded.
- State machine states: IDLE, SHIFT, DONE.
  - s_ready=1 only in IDLE.
  - m_valid=1 only in DONE.
- IDLE, on s_valid=1: latch the operand, latch the target, and compute diff = signed(target) − signed({overflow, exponent}) with one extra bit.
  - If type != `FPIR_TYPE_NORMAL: pass through unchanged and go to DONE.
  - If diff < 0: pass through unchanged, set m_target_below=1, go to DONE.
  - If diff == 0: pass through unchanged and go to DONE.
  - Otherwise: remaining = min(diff, W+1), set m_underflow_shift = (diff ≥ W+1), go to SHIFT.
- SHIFT, each cycle:
  - step = min(remaining, SHIFT_PER_CYCLE).
  - ext = ext >> step, with zero fill from the MSB.
  - New LSB = (shifted LSB) OR (OR of all bits shifted out, including the old LSB).
  - remaining -= step.
  - When remaining reaches 0, go to DONE.
- DONE, output fields:
  - exponent/overflow fields = target.
  - sign unchanged.
  - If the original type was NORMAL and the final ext is all zero (sticky included), type becomes FPIR_TYPE_MZERO or FPIR_TYPE_PZERO according to sign; otherwise type is unchanged.
- DONE, handshake:
  - m_value and the flags are held stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: go to IDLE and clear the flags.
  - A new operand cannot be accepted in the same cycle as a DONE handshake.
- Latency: the operand is accepted in cycle T and m_valid rises at T+1+ceil(min(diff, W+1)/SHIFT_PER_CYCLE). Pass-through operands have m_valid at T+1.
- clear=1 has priority over every transition: go to IDLE, m_valid=0, flags cleared. A clear arriving together with s_valid in IDLE does not accept the operand.
- Arithmetic width rules:
  - diff is computed in BW_OVERFLOW+BW_EXPONENT+1 bits, signed.
  - The remaining counter is REQUIRED_BITWIDTH_INDEX(W+2) bits wide.
  - No wrap-around: the clamp is applied before loading the counter.

Test Plan:
- Defaults, NORMAL operand with exp=100, ext=27'h4000001, target=103 → m_valid at T+2; ext=27'h0800001 (sticky set); exponent=103; type NORMAL; flags 0.
- NORMAL operand with ext=27'h4000000, exp=10, target=50 (diff=40 ≥ 28) → m_underflow_shift=1; ext=27'h0000001; m_valid at T+1+7=T+8; type NORMAL.
- NORMAL operand with ext=0 (sign=1), diff=5 → type FPIR_TYPE_MZERO; exponent=target.
- INF operand, or any operand with target < exp → m_valid at T+1; value unchanged; m_target_below=1 only in the target<exp case.
- Hold m_ready=0 for 5 cycles in DONE → m_value stable, s_ready=0; release → IDLE next cycle and s_ready=1.
- Assert rstnn=0 mid-SHIFT, and separately clear=1 mid-SHIFT → next edge is IDLE with m_valid=0; a subsequent operand is processed correctly.
